// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the default prefetch-buffer entry type.
package fetch_pkg;
  localparam int unsigned PC_INC = 4;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_INST_W = 32;
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO with flush; push and pop may coincide even when full.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 2,
  parameter type T = fetch_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
  assign dout  = mem[rd_ptr];
  assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetcher with in-order response buffer and redirect discard.
// Define FETCH_ALIGN_CHK_EN to flag misaligned redirects and halt fetch until an aligned one.
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              misalign_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;
  entry_t head, push_entry;
  logic [ADDR_W-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] count, inflight, discard;
  logic [CW:0] occupancy;
  logic empty, push, pop, fire, halted;
`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clock) begin
    if (reset) misalign_err <= 1'b0;
    else if (redirect_valid) misalign_err <= |redirect_pc[1:0];
  end
  assign target = redirect_pc;
`else
  assign misalign_err = 1'b0;
  assign target = redirect_pc & ~ADDR_W'(3);
`endif
  assign halted = misalign_err;
  assign inst_valid = !empty && !redirect_valid && !reset;
  assign pop = inst_valid && inst_ready;
  // A pop this cycle frees a slot, which keeps one instruction per cycle with DEPTH=2.
  assign occupancy = {1'b0, count} + {1'b0, inflight} - (CW+1)'(pop);
  assign imem_req = occupancy < (CW+1)'(DEPTH) && !redirect_valid && !halted && !reset;
  assign fire = imem_req && imem_ready;
  assign push = imem_rvalid && !redirect_valid && discard == '0;
  assign push_entry = '{pc: resp_pc, inst: imem_rdata};
  assign imem_addr = fetch_pc;
  assign inst_pc = head.pc;
  assign inst_data = head.inst;
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CW'(fire) - CW'(imem_rvalid);
      fetch_pc <= redirect_valid ? target : fire ? fetch_pc + ADDR_W'(PC_INC) : fetch_pc;
      resp_pc  <= redirect_valid ? target : push ? resp_pc + ADDR_W'(PC_INC) : resp_pc;
      discard  <= redirect_valid ? inflight - CW'(imem_rvalid)
                : (imem_rvalid && discard != '0) ? discard - CW'(1) : discard;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .din(push_entry),
    .pop(pop),
    .dout(head),
    .count(count),
    .empty(empty)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven per-cycle vectors plus reset and alignment sequences.
module tb_fetch_unit;
  localparam logic [31:0] A = 32'h0040_0000;
`ifdef FETCH_ALIGN_CHK_EN
  localparam logic [31:0] MIS_PC = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_PC = 32'h0000_0103;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic inst_valid, inst_ready = 1'b0, redirect_valid = 1'b0, misalign_err;
  logic [31:0] imem_addr, imem_rdata = '0, inst_data, inst_pc, redirect_pc = '0;
  int checks = 0, fails = 0;
  typedef struct {
    logic rdy, rv;
    logic [31:0] rdata;
    logic irdy, redir;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic iv;
    logic [31:0] ipc, idata;
  } vec_t;
  vec_t vecs[$];
  fetch_unit dut (
    .clock(clock),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );
  always #5 clock = ~clock;
  function automatic vec_t v(input logic rdy, rv, input logic [31:0] rdata, input logic irdy, redir,
                             input logic [31:0] rpc, input logic req, input logic [31:0] addr,
                             input logic iv, input logic [31:0] ipc, idata);
    v = '{rdy, rv, rdata, irdy, redir, rpc, req, addr, iv, ipc, idata};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic rdy, rv, input logic [31:0] rd, input logic ir, rdr, input logic [31:0] rp);
    imem_ready = rdy;
    imem_rvalid = rv;
    imem_rdata = rd;
    inst_ready = ir;
    redirect_valid = rdr;
    redirect_pc = rp;
  endtask
  initial begin
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, A,          0, 0,      0));
    vecs.push_back(v(1, 1, 'hD0,  1, 0, 0, 1, A + 'h4,    0, 0,      0));
    vecs.push_back(v(1, 1, 'hD1,  1, 0, 0, 1, A + 'h8,    1, A,      'hD0));
    vecs.push_back(v(1, 1, 'hD2,  1, 0, 0, 1, A + 'hC,    1, A + 'h4, 'hD1));
    vecs.push_back(v(1, 1, 'hD3,  0, 0, 0, 0, 0,          1, A + 'h8, 'hD2));
    vecs.push_back(v(1, 0, 0,     0, 0, 0, 0, 0,          1, A + 'h8, 'hD2));
    vecs.push_back(v(1, 0, 0,     0, 0, 0, 0, 0,          1, A + 'h8, 'hD2));
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, A + 'h10,   1, A + 'h8, 'hD2));
    vecs.push_back(v(1, 1, 'hD4,  1, 0, 0, 1, A + 'h14,   1, A + 'hC, 'hD3));
    vecs.push_back(v(0, 1, 'hD5,  1, 0, 0, 1, A + 'h18,   1, A + 'h10, 'hD4));
    vecs.push_back(v(1, 0, 0,     0, 0, 0, 1, A + 'h18,   1, A + 'h14, 'hD5));
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, A + 'h1C,   1, A + 'h14, 'hD5));
    vecs.push_back(v(1, 0, 0,     1, 1, 'h100, 0, 0,      0, 0,      0));
    vecs.push_back(v(1, 1, 'hEE,  1, 0, 0, 0, 0,          0, 0,      0));
    vecs.push_back(v(1, 1, 'hEF,  1, 0, 0, 1, 'h100,      0, 0,      0));
    vecs.push_back(v(1, 1, 'hE0,  1, 0, 0, 1, 'h104,      0, 0,      0));
    vecs.push_back(v(1, 1, 'hE1,  0, 0, 0, 0, 0,          1, 'h100,  'hE0));
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, 'h108,      1, 'h100,  'hE0));
    vecs.push_back(v(1, 1, 'hE2,  1, 1, 'h200, 0, 0,      0, 0,      0));
    vecs.push_back(v(0, 0, 0,     1, 0, 0, 1, 'h200,      0, 0,      0));
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, 'h200,      0, 0,      0));
    vecs.push_back(v(1, 1, 'hF0,  1, 0, 0, 1, 'h204,      0, 0,      0));
    vecs.push_back(v(0, 1, 'hF1,  1, 0, 0, 1, 'h208,      1, 'h200,  'hF0));
    vecs.push_back(v(0, 0, 0,     1, 0, 0, 1, 'h208,      1, 'h204,  'hF1));
    vecs.push_back(v(1, 0, 0,     1, 1, MIS_PC, 0, 0,     0, 0,      0));
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, 'h100,      0, 0,      0));
    vecs.push_back(v(0, 1, 'hA0,  1, 0, 0, 1, 'h104,      0, 0,      0));
    vecs.push_back(v(0, 0, 0,     1, 0, 0, 1, 'h104,      1, 'h100,  'hA0));
    vecs.push_back(v(1, 0, 0,     1, 1, 'hFFFF_FFFC, 0, 0, 0, 0,     0));
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, 'hFFFF_FFFC, 0, 0,     0));
    vecs.push_back(v(1, 1, 'hB0,  1, 0, 0, 1, 0,          0, 0,      0));
    vecs.push_back(v(0, 1, 'hB1,  1, 0, 0, 1, 'h4,        1, 'hFFFF_FFFC, 'hB0));
    vecs.push_back(v(0, 0, 0,     1, 0, 0, 1, 'h4,        1, 0,      'hB1));
    vecs.push_back(v(1, 0, 0,     1, 1, 'h300, 0, 0,      0, 0,      0));
    vecs.push_back(v(1, 0, 0,     1, 1, 'h400, 0, 0,      0, 0,      0));
    vecs.push_back(v(1, 0, 0,     1, 0, 0, 1, 'h400,      0, 0,      0));
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clock);
    chk("reset_req", 32'(imem_req), 0);
    chk("reset_valid", 32'(inst_valid), 0);
    @(negedge clock);
    chk("reset_err", 32'(misalign_err), 0);
    reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].irdy, vecs[i].redir, vecs[i].rpc);
      #1;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
      if (vecs[i].iv) begin
        chk($sformatf("v%0d_pc", i), inst_pc, vecs[i].ipc);
        chk($sformatf("v%0d_data", i), inst_data, vecs[i].idata);
      end
      chk($sformatf("v%0d_err", i), 32'(misalign_err), 0);
      @(negedge clock);
    end
    reset = 1'b1;
    drive(1, 0, 0, 1, 0, 0);
    #1;
    chk("midreset_req", 32'(imem_req), 0);
    chk("midreset_valid", 32'(inst_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    #1;
    chk("postreset_req", 32'(imem_req), 1);
    chk("postreset_addr", imem_addr, A);
    chk("postreset_valid", 32'(inst_valid), 0);
    @(negedge clock);
`ifdef FETCH_ALIGN_CHK_EN
    drive(1, 0, 0, 1, 1, 32'h0000_0102);
    #1;
    chk("mis_redir_req", 32'(imem_req), 0);
    @(negedge clock);
    drive(1, 0, 0, 1, 0, 0);
    #1;
    chk("mis_err_set", 32'(misalign_err), 1);
    chk("mis_halt_req", 32'(imem_req), 0);
    @(negedge clock);
    #1;
    chk("mis_err_sticky", 32'(misalign_err), 1);
    chk("mis_still_halted", 32'(imem_req), 0);
    @(negedge clock);
    drive(1, 0, 0, 1, 1, 32'h0000_0200);
    #1;
    chk("align_redir_req", 32'(imem_req), 0);
    @(negedge clock);
    drive(1, 0, 0, 1, 0, 0);
    #1;
    chk("align_err_clr", 32'(misalign_err), 0);
    chk("align_resume_req", 32'(imem_req), 1);
    chk("align_resume_addr", imem_addr, 32'h0000_0200);
    @(negedge clock);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
